// File: rtl/fb_pkg.sv
// Shared geometry, VGA active-area origin and state encodings for the
// framebuffer arbiter slice.
package fb_pkg;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int SCALE    = 4;
  localparam int COLOR_W  = 8;
  localparam int ADDR_W   = 15;
  localparam int H_ORIGIN = 145;
  localparam int V_ORIGIN = 36;
  localparam int FB_SIZE  = FB_W * FB_H;

  typedef enum logic {IDLE, CLEAR} clr_state_e;
  typedef enum logic {GNT_DRAW, GNT_CLEAR} grant_e;

endpackage

// File: rtl/fb_scan_addr.sv
// Maps the VGA beam position to a framebuffer address; outside the active
// area the fetch is flagged blank and the address parks at 0.
module fb_scan_addr #(
  parameter int FB_W   = fb_pkg::FB_W,
  parameter int SCALE  = fb_pkg::SCALE,
  parameter int ADDR_W = fb_pkg::ADDR_W
) (
  input  logic [10:0]       x,
  input  logic [10:0]       y,
  input  logic              ativo_vga,
  output logic [ADDR_W-1:0] addr,
  output logic              blank
);
  import fb_pkg::*;

  localparam int SHIFT = $clog2(SCALE);

  logic [10:0] dx;
  logic [10:0] dy;
  logic [10:0] col;
  logic [10:0] row;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    dx    = x - 11'(H_ORIGIN);
    dy    = y - 11'(V_ORIGIN);
    col   = dx >> SHIFT;
    row   = dy >> SHIFT;
    blank = !ativo_vga;
    addr  = '0;
    if (ativo_vga) begin
      addr = ADDR_W'(row) * ADDR_W'(FB_W) + ADDR_W'(col);
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer scheduler: read slots feed VGA scan-out, write slots
// are shared round-robin between the drawing port and the screen-clear engine.
module fb_arbiter #(
  parameter int FB_W    = fb_pkg::FB_W,
  parameter int FB_H    = fb_pkg::FB_H,
  parameter int SCALE   = fb_pkg::SCALE,
  parameter int COLOR_W = fb_pkg::COLOR_W,
  parameter int ADDR_W  = fb_pkg::ADDR_W
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               pix_phase,
  input  logic [10:0]        x,
  input  logic [10:0]        y,
  input  logic               ativo_vga,
  output logic [COLOR_W-1:0] pixel_out,
  input  logic               wr_req,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  output logic               wr_ack,
  input  logic               clr_start,
  input  logic [COLOR_W-1:0] clr_color,
  output logic               clr_busy,
  output logic               clr_done,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata
);
  import fb_pkg::*;

  localparam int                CELLS     = FB_W * FB_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  logic [ADDR_W-1:0] scan_addr;
  logic              scan_blank;

  fb_scan_addr #(.FB_W(FB_W), .SCALE(SCALE), .ADDR_W(ADDR_W)) u_scan (
    .x         (x),
    .y         (y),
    .ativo_vga (ativo_vga),
    .addr      (scan_addr),
    .blank     (scan_blank)
  );

  clr_state_e        state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [COLOR_W-1:0] clr_color_q, clr_color_d;
  logic              clr_done_q, clr_done_d;
  logic              blank_q, blank_d;
  logic [COLOR_W-1:0] pixel_q, pixel_d;

  logic   clr_active;
  logic   grant_vld;
  grant_e grant;
  logic   wr_in_range;

  assign clr_active  = (state_q == CLEAR);
  assign wr_in_range = 32'(wr_addr) < 32'(CELLS);

  // A tie goes to whoever lost the previous write slot.
  always_comb begin
    grant_vld = 1'b0;
    grant     = last_grant_q;
    if (pix_phase && !reset) begin
      if (wr_req && clr_active) begin
        grant_vld = 1'b1;
        grant     = (last_grant_q == GNT_CLEAR) ? GNT_DRAW : GNT_CLEAR;
      end else if (wr_req) begin
        grant_vld = 1'b1;
        grant     = GNT_DRAW;
      end else if (clr_active) begin
        grant_vld = 1'b1;
        grant     = GNT_CLEAR;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    wr_ack    = 1'b0;
    if (!reset) begin
      if (!pix_phase) begin
        mem_addr = scan_addr;
      end else if (grant_vld && grant == GNT_DRAW) begin
        wr_ack = 1'b1;
        if (wr_in_range) begin
          mem_we    = 1'b1;
          mem_addr  = wr_addr;
          mem_wdata = wr_data;
        end
      end else if (grant_vld) begin
        mem_we    = 1'b1;
        mem_addr  = clr_ptr_q;
        mem_wdata = clr_color_q;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    clr_color_d  = clr_color_q;
    clr_done_d   = 1'b0;
    last_grant_d = grant_vld ? grant : last_grant_q;
    blank_d      = pix_phase ? blank_q : scan_blank;
    pixel_d      = pixel_q;
    if (pix_phase) begin
      pixel_d = blank_q ? '0 : mem_rdata;
    end
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d     = CLEAR;
          clr_ptr_d   = '0;
          clr_color_d = clr_color;
        end
      end
      CLEAR: begin
        if (grant_vld && grant == GNT_CLEAR) begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
          if (clr_ptr_q == LAST_ADDR) begin
            state_d    = IDLE;
            clr_ptr_d  = '0;
            clr_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_CLEAR;
      clr_ptr_q    <= '0;
      clr_color_q  <= '0;
      clr_done_q   <= 1'b0;
      blank_q      <= 1'b1;
      pixel_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      clr_ptr_q    <= clr_ptr_d;
      clr_color_q  <= clr_color_d;
      clr_done_q   <= clr_done_d;
      blank_q      <= blank_d;
      pixel_q      <= pixel_d;
    end
  end

  assign pixel_out = pixel_q;
  assign clr_busy  = clr_active;
  assign clr_done  = clr_done_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: scan-address table, scan-out and blanking,
// drawing writes, contended full clear against a RAM model, reset mid-clear.
module tb_fb_arbiter;
  import fb_pkg::*;

  localparam int N = FB_W * FB_H;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_phase;
  logic [10:0] x;
  logic [10:0] y;
  logic        ativo_vga;
  logic [7:0]  pixel_out;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        clr_start;
  logic [7:0]  clr_color;
  logic        clr_busy;
  logic        clr_done;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram     [0:32767];
  logic [7:0]  exp_mem [0:N-1];
  logic        fill;
  logic        poke_en;
  logic [14:0] poke_addr;
  logic [7:0]  poke_data;

  int n_checks = 0;
  int n_errors = 0;

  fb_arbiter dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .pix_phase (pix_phase),
    .x         (x),
    .y         (y),
    .ativo_vga (ativo_vga),
    .pixel_out (pixel_out),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #10 clk = ~clk;

  // Synchronous single-port RAM, read-before-write, one cycle read latency.
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (fill) begin
      for (int a = 0; a < 32768; a++) ram[a] = 8'hAA;
    end else if (poke_en) begin
      ram[poke_addr] = poke_data;
    end
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic        ativo;
    logic [14:0] addr;
  } scan_vec_t;

  scan_vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pix_phase = ~pix_phase;
  endtask

  task automatic goto_read();
    step();
    if (pix_phase) step();
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic poke(input logic [14:0] a, input logic [7:0] d);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    step();
    poke_en   = 1'b0;
  endtask

  function automatic logic [14:0] draw_addr(input int k);
    return 15'((k * 97 + 13) % N);
  endfunction

  function automatic logic [7:0] draw_data(input int k);
    return 8'(k) | 8'h01;
  endfunction

  initial begin
    int k, clr_cnt, ws, seq_err, mism, cnt, err;
    logic done_seen, expect_done;

    vecs[0] = '{x: 11'd145, y: 11'd36,  ativo: 1'b1, addr: 15'd0};
    vecs[1] = '{x: 11'd149, y: 11'd40,  ativo: 1'b1, addr: 15'd161};
    vecs[2] = '{x: 11'd148, y: 11'd39,  ativo: 1'b1, addr: 15'd0};
    vecs[3] = '{x: 11'd300, y: 11'd100, ativo: 1'b1, addr: 15'd2598};
    vecs[4] = '{x: 11'd783, y: 11'd515, ativo: 1'b1, addr: 15'd19199};
    vecs[5] = '{x: 11'd500, y: 11'd300, ativo: 1'b0, addr: 15'd0};

    reset = 1'b1; pix_phase = 1'b0; fill = 1'b1; poke_en = 1'b0;
    poke_addr = '0; poke_data = '0;
    x = '0; y = '0; ativo_vga = 1'b0;
    wr_req = 1'b1; wr_addr = 15'd5; wr_data = 8'h11;
    clr_start = 1'b0; clr_color = '0;

    // Reset state, observed in a write slot with a request pending.
    step(); fill = 1'b0;
    step(); step();
    sample();
    check("rst_pixel_out", pixel_out, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_clr_done", clr_done, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    step(); reset = 1'b0; wr_req = 1'b0;

    // Scan-address table, read slots only.
    for (int i = 0; i < 6; i++) begin
      goto_read();
      x = vecs[i].x; y = vecs[i].y; ativo_vga = vecs[i].ativo;
      sample();
      check($sformatf("scan_addr[%0d]", i), mem_addr, vecs[i].addr);
      check($sformatf("scan_we[%0d]", i), mem_we, 0);
    end

    // Scan-out latency and hold over a full pixel.
    poke(15'd0, 8'h5A);
    goto_read();
    x = 11'd145; y = 11'd36; ativo_vga = 1'b1;
    step(); step();
    sample();
    check("scanout_pixel", pixel_out, 8'h5A);
    step();
    sample();
    check("scanout_hold", pixel_out, 8'h5A);

    // Blanking overrides RAM contents.
    poke(15'd0, 8'hFF);
    goto_read();
    ativo_vga = 1'b0;
    sample();
    check("blank_mem_we", mem_we, 0);
    step(); step();
    sample();
    check("blank_pixel", pixel_out, 0);

    // Drawing write requested in a read slot.
    goto_read();
    wr_req = 1'b1; wr_addr = 15'd100; wr_data = 8'h3C;
    sample();
    check("draw_read_slot_ack", wr_ack, 0);
    check("draw_read_slot_we", mem_we, 0);
    step();
    sample();
    check("draw_ack", wr_ack, 1);
    check("draw_we", mem_we, 1);
    check("draw_addr", mem_addr, 100);
    check("draw_wdata", mem_wdata, 8'h3C);
    step(); wr_req = 1'b0;
    sample();
    check("draw_ram", ram[100], 8'h3C);

    // Out-of-range write: acknowledged, dropped.
    goto_read();
    step();
    wr_req = 1'b1; wr_addr = 15'd19200; wr_data = 8'h77;
    sample();
    check("oor_ack", wr_ack, 1);
    check("oor_we", mem_we, 0);
    step(); wr_req = 1'b0;

    // Contended full clear, starting from a fresh reset so drawing wins the first tie.
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    goto_read();
    k = 0; clr_cnt = 0; ws = 0; seq_err = 0;
    done_seen = 1'b0; expect_done = 1'b0;
    clr_start = 1'b1; clr_color = 8'h00;
    wr_req = 1'b1; wr_addr = draw_addr(0); wr_data = draw_data(0);
    for (int n = 0; n < 78000 && !done_seen; n++) begin
      step();
      clr_start = (n == 1000);
      clr_color = (n == 1000) ? 8'hEE : 8'h00;
      wr_req  = 1'b1;
      wr_addr = draw_addr(k);
      wr_data = draw_data(k);
      sample();
      if (n == 0) check("clr_busy_after_start", clr_busy, 1);
      if (expect_done) begin
        check("clr_done_pulse", clr_done, 1);
        check("clr_busy_fall", clr_busy, 0);
        done_seen = 1'b1;
      end else begin
        if (clr_done || !clr_busy) seq_err++;
        if (pix_phase) begin
          if (ws == 0) check("first_tie_draw", wr_ack, 1);
          if (ws == 1) check("second_slot_clear", {wr_ack, mem_we, mem_addr}, {1'b0, 1'b1, 15'd0});
          if (ws % 2 == 0) begin
            if (!(wr_ack === 1'b1 && mem_we === 1'b1 && mem_addr === draw_addr(k) &&
                  mem_wdata === draw_data(k))) seq_err++;
            exp_mem[draw_addr(k)] = draw_data(k);
            k++;
          end else begin
            if (!(wr_ack === 1'b0 && mem_we === 1'b1 && mem_addr === 15'(clr_cnt) &&
                  mem_wdata === 8'h00)) seq_err++;
            exp_mem[clr_cnt] = 8'h00;
            clr_cnt++;
            if (clr_cnt == N) expect_done = 1'b1;
          end
          ws++;
        end else if (mem_we || wr_ack) begin
          seq_err++;
        end
      end
    end
    wr_req = 1'b0; clr_start = 1'b0;
    check("clr_done_seen", done_seen, 1);
    check("contention_seq_errors", seq_err, 0);
    check("clear_write_count", clr_cnt, N);
    step();
    sample();
    check("clr_done_single_cycle", clr_done, 0);
    mism = 0;
    for (int a = 0; a < N; a++) if (ram[a] !== exp_mem[a]) mism++;
    check("ram_after_clear", mism, 0);

    // Reset in the middle of a clear.
    goto_read();
    clr_start = 1'b1; clr_color = 8'h11;
    step();
    clr_start = 1'b0;
    cnt = 0;
    for (int n = 0; n < 2000 && cnt < 500; n++) begin
      sample();
      if (pix_phase && mem_we) cnt++;
      if (cnt < 500) step();
    end
    check("mid_clear_reached", cnt, 500);
    step();
    reset = 1'b1; wr_req = 1'b1; wr_addr = 15'd7; wr_data = 8'h99;
    step();
    sample();
    check("midrst_busy", clr_busy, 0);
    check("midrst_done", clr_done, 0);
    check("midrst_ack", {wr_ack, mem_we}, 0);
    step();
    reset = 1'b0; wr_req = 1'b0;
    err = 0;
    for (int n = 0; n < 4; n++) begin
      sample();
      if (clr_done || clr_busy) err++;
      step();
    end
    check("midrst_no_done", err, 0);
    goto_read();
    clr_start = 1'b1; clr_color = 8'h22;
    step();
    clr_start = 1'b0;
    sample();
    check("restart_busy", clr_busy, 1);
    check("restart_first_write", {mem_we, mem_addr, mem_wdata}, {1'b1, 15'd0, 8'h22});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Time-division scheduler for a single-port synchronous framebuffer RAM behind the VGA timing generator. It grants every read slot to scan-out, using the VGA `x`/`y`/`ativo_vga` counters to fetch the current pixel. It shares every write slot round-robin between an external drawing requester and a built-in screen-clear sequencer. It sits between the VGA timing block, the game/drawing logic and the framebuffer RAM.

## Interface
Parameters:
- `FB_W`, 160: framebuffer columns.
- `FB_H`, 120: framebuffer rows.
- `SCALE`, 4: screen pixels per framebuffer pixel, per axis.
- `COLOR_W`, 8: bits per pixel.
- `ADDR_W`, 15: RAM address width; must satisfy `FB_W*FB_H <= 2**ADDR_W`.

Ports:
- `CLOCK_50`, in, 1: sole clock.
- `reset`, in, 1: synchronous, active-high.
- `pix_phase`, in, 1: level of the 25 MHz pixel clock, sampled as data. 0 marks a read slot; 1 marks a write slot.
- `x`, in, 11: VGA horizontal counter.
- `y`, in, 11: VGA vertical counter.
- `ativo_vga`, in, 1: VGA active-area flag.
- `pixel_out`, out, COLOR_W: registered scan-out colour.
- `wr_req`, in, 1: drawing write request.
- `wr_addr`, in, ADDR_W: drawing write address.
- `wr_data`, in, COLOR_W: drawing write data.
- `wr_ack`, out, 1: one-cycle acknowledge; the write happens in this cycle.
- `clr_start`, in, 1: pulse; starts a full-screen clear.
- `clr_color`, in, COLOR_W: fill colour, sampled when `clr_start` is accepted.
- `clr_busy`, out, 1: clear in progress.
- `clr_done`, out, 1: one-cycle pulse when the clear completes.
- `mem_addr`, out, ADDR_W: RAM address.
- `mem_we`, out, 1: RAM write enable.
- `mem_wdata`, out, COLOR_W: RAM write data.
- `mem_rdata`, in, COLOR_W: RAM read data, valid one cycle after the address.

## Operation
- Read slot (`pix_phase`=0):
  - `mem_we`=0.
  - `mem_addr` = `((y-36)/SCALE)*FB_W + (x-145)/SCALE`.
  - Divide by shifting, since SCALE is a power of two.
  - When `ativo_vga`=0, `mem_addr`=0 and the fetch is flagged blank.
- Following write slot: `pixel_out` <= `mem_rdata` at the end of the cycle. If the fetch was flagged blank, `pixel_out` <= 0 instead.
- Write slot (`pix_phase`=1): at most one write, granted to drawing or clear.
  - Only one contender: that contender is granted.
  - Both contending: the one not granted last time wins.
  - `last_grant` resets to CLEAR, so drawing wins the first tie.
- Drawing grant: `mem_we`=1, `mem_addr`=`wr_addr`, `mem_wdata`=`wr_data`, `wr_ack`=1 in the same cycle.
  - The requester holds `wr_req`/`wr_addr`/`wr_data` stable until `wr_ack`.
  - The requester may present a new request in the next cycle.
  - If `wr_addr >= FB_W*FB_H`: `mem_we`=0, but `wr_ack` is still issued and the write is dropped.
- Clear FSM, state IDLE:
  - `clr_start`=1 -> CLEAR.
  - On entry: `clr_ptr`=0, `clr_color` latched, `clr_busy`=1 from the next cycle.
- Clear FSM, state CLEAR:
  - Each granted slot writes the latched colour to `clr_ptr`, then increments `clr_ptr`.
  - The grant that writes `FB_W*FB_H-1` returns to IDLE and pulses `clr_done` in the following cycle, when `clr_busy` falls.
  - `clr_start` while in CLEAR is ignored.
- Outputs outside a write grant: `mem_we`=0 and `mem_wdata`=0.

## Timing
- Reset values:
  - `pixel_out`=0, `wr_ack`=0, `clr_busy`=0, `clr_done`=0.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - FSM in IDLE, `clr_ptr`=0, `last_grant`=CLEAR.
- Reset mid-clear aborts the clear with no `clr_done`. Any pending drawing request is not acknowledged.
- Scan-out latency: 2 `CLOCK_50` cycles (one pixel) from address to `pixel_out`. The image is shifted right by one pixel; this is accepted.
- `pixel_out` is stable for a whole `pix_phase` period.
- Drawing write latency:
  - Uncontended: ≤ 2 cycles from `wr_req` to `wr_ack`.
  - With a clear active: ≤ 4 cycles.
- Clear duration: `FB_W*FB_H` granted slots. That is 38400 cycles alone, or ≤ 76800 cycles with continuous drawing traffic.
- `mem_addr`/`mem_we` are combinational from the slot and the grant.

## Structure
- Package `fb_pkg`:
  - `FB_W`, `FB_H`, `SCALE`, `COLOR_W`, `ADDR_W`.
  - Active-area origin constants `H_ORIGIN`=145 and `V_ORIGIN`=36.
  - `FB_SIZE`.
  - Clear-state enum {IDLE, CLEAR}.
  - Grant enum {GNT_DRAW, GNT_CLEAR}.
- Sub-module `fb_scan_addr`: combinational mapping of `x`/`y`/`ativo_vga` to address plus blank flag; testable alone.

## Test plan
- Scan-out: x=145, y=36, `ativo_vga`=1, RAM[0]=0x5A -> `pixel_out`=0x5A after 2 cycles. At x=149, y=40, `mem_addr`=161.
- Blank: `ativo_vga`=0 with RAM[0]=0xFF -> `pixel_out`=0 and `mem_we`=0 in read slots.
- Drawing write: `wr_req`, addr 100, data 0x3C, asserted in a read slot -> `wr_ack` one cycle later. `mem_we`=1 with addr 100 and data 0x3C; no write in any read slot.
- Out-of-range: `wr_addr`=19200 -> `wr_ack`=1, `mem_we`=0.
- Contention: clear (0x00) started with continuous `wr_req` -> grants alternate DRAW, CLEAR, DRAW... `clr_done` arrives after 19200 clear writes. RAM is fully 0x00 except addresses the drawing requester wrote after being cleared.
- Reset mid-clear at `clr_ptr`=500 -> next cycle `clr_busy`=0, no `clr_done`, `clr_ptr`=0. A fresh `clr_start` restarts at address 0.
